// File: rtl/bc_fifo.sv
// Broadcast stage with per-consumer elastic buffering.
// One producer stream is copied into SIZE independent DEPTH-entry FIFOs, so a
// slow consumer only stalls the producer once its own FIFO is full.
// Optional feature: define BC_FIFO_BYPASS_EN for a zero-latency bypass. With it,
// an empty channel presents the incoming word combinationally and skips storage
// when its consumer takes the word in that same cycle.

module bc_fifo #(
  parameter int SIZE  = 2,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  din_ready,
  input  logic                  din_valid,
  input  logic [WIDTH-1:0]      din_data,
  input  logic [SIZE-1:0]       dout_ready,
  output logic [SIZE-1:0]       dout_valid,
  output logic [SIZE*WIDTH-1:0] dout_data
);

  localparam int AW = $clog2(DEPTH);

  // The MSB of each pointer is the wrap bit.
  typedef logic [AW:0] ptr_t;

  ptr_t             wptr_q [SIZE];
  ptr_t             wptr_d [SIZE];
  ptr_t             rptr_q [SIZE];
  ptr_t             rptr_d [SIZE];
  logic [WIDTH-1:0] mem_q  [SIZE][DEPTH];

  logic [SIZE-1:0] empty;
  logic [SIZE-1:0] full;
  logic [SIZE-1:0] wr_en;
  logic [SIZE-1:0] rd_en;
  logic            push;

  // Per-channel occupancy flags, derived only from the registered pointers.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < SIZE; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) && (wptr_q[i][AW] != rptr_q[i][AW]);
    end
  end

  // All-or-nothing push. There is no dependence on dout_ready, so a pop on a
  // full channel frees room only in the following cycle.
  assign din_ready = !rst && !(|full);
  assign push      = din_valid && din_ready;

  // Output muxing plus per-channel write and read enables.
  always_comb begin
    dout_valid = '0;
    dout_data  = '0;
    wr_en      = '0;
    rd_en      = '0;
    for (int i = 0; i < SIZE; i++) begin
`ifdef BC_FIFO_BYPASS_EN
      if (empty[i]) begin
        // The incoming word goes straight through. It is stored only when
        // consumer i does not take it in this cycle.
        dout_valid[i]                 = push;
        dout_data[i*WIDTH +: WIDTH]   = din_data;
        wr_en[i]                      = push && !dout_ready[i];
        rd_en[i]                      = 1'b0;
      end else begin
        dout_valid[i]                 = 1'b1;
        dout_data[i*WIDTH +: WIDTH]   = mem_q[i][rptr_q[i][AW-1:0]];
        wr_en[i]                      = push;
        rd_en[i]                      = dout_ready[i];
      end
`else
      dout_valid[i]                   = !empty[i];
      dout_data[i*WIDTH +: WIDTH]     = mem_q[i][rptr_q[i][AW-1:0]];
      wr_en[i]                        = push;
      rd_en[i]                        = !empty[i] && dout_ready[i];
`endif
    end
  end

  // Next-state pointers; the wrap bit carries naturally.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      wptr_d[i] = wr_en[i] ? wptr_q[i] + ptr_t'(1) : wptr_q[i];
      rptr_d[i] = rd_en[i] ? rptr_q[i] + ptr_t'(1) : rptr_q[i];
    end
  end

  // Pointer registers; reset drops every buffered word in all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Storage array; it is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= din_data;
      end
    end
  end

endmodule

// File: tb/tb_bc_fifo.sv
// Self-checking bench for bc_fifo (SIZE=2, WIDTH=16, DEPTH=4).
// The driver pushes the expected words into per-channel queues on acceptance.
// A monitor pops the queues and compares whenever a channel transfers.
module tb_bc_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_ready;
  logic        din_valid = 1'b0;
  logic [15:0] din_data = '0;
  logic [1:0]  dout_ready = 2'b00;
  logic [1:0]  dout_valid;
  logic [31:0] dout_data;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          stalls = 0;
  bit          rand_mode = 1'b0;

  bc_fifo #(
    .SIZE (2),
    .WIDTH(16),
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_ready (din_ready),
    .din_valid (din_valid),
    .din_data  (din_data),
    .dout_ready(dout_ready),
    .dout_valid(dout_valid),
    .dout_data (dout_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pop_check(input int ch, input logic [15:0] got);
    logic [15:0] exp;
    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
      total_cnt++;
      $display("FAIL ch%0d_underflow: got %h expected no word", ch, got);
    end else begin
      if (ch == 0) exp = q0.pop_front();
      else exp = q1.pop_front();
      check($sformatf("ch%0d_data", ch), 32'(got), 32'(exp));
    end
  endtask

  // Monitor: compare every channel transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (dout_valid[0] && dout_ready[0]) pop_check(0, dout_data[15:0]);
        if (dout_valid[1] && dout_ready[1]) pop_check(1, dout_data[31:16]);
      end
    end
  end

  // Drive one word; returns at posedge+1 after the accepting edge, din_valid left high.
  task automatic push_word(input logic [15:0] w);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    din_valid = 1'b1;
    din_data  = w;
    while (!done) begin
      @(negedge clk);
      if (din_ready) begin
        q0.push_back(w);
        q1.push_back(w);
        done = 1'b1;
      end else begin
        stalls++;
        n++;
      end
      @(posedge clk);
      #1;
      if (rand_mode) dout_ready = 2'($urandom_range(0, 3));
      if (!done && n > 50) begin
        total_cnt++;
        $display("FAIL push_timeout: got no acceptance expected accept of %h", w);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    din_valid  = 1'b0;
    dout_ready = 2'b11;
    repeat (8) @(posedge clk);
    #1;
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_valid", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #6;
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_din_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream, both consumers ready
    dout_ready = 2'b11;
    stalls = 0;
    check("idle_valid", 32'(dout_valid), 32'd0);
    push_word(16'h0001);
`ifndef BC_FIFO_BYPASS_EN
    check("latency_valid", 32'(dout_valid), 32'h3);
    check("latency_data", dout_data, 32'h0001_0001);
`endif
    for (int i = 2; i <= 8; i++) push_word(16'(i));
    check("stream_stalls", 32'(stalls), 32'd0);
    drain();

    // Channel 1 blocked: fills after four words
    dout_ready = 2'b01;
    for (int i = 1; i <= 4; i++) push_word(16'h0010 + 16'(i));
    din_data = 16'h0015;
    check("full_ready_low", 32'(din_ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("full_hold", 32'(din_ready), 32'd0);
    end
    // Pop the full channel while din_valid=1: still no push this cycle
    dout_ready = 2'b11;
    #3;
    check("full_pop_same_cycle", 32'(din_ready), 32'd0);
    @(posedge clk);
    #1;
    check("room_next_cycle", 32'(din_ready), 32'd1);
    push_word(16'h0015);
    push_word(16'h0016);
    drain();

    // Asynchronous reset mid-cycle discards buffered words
    dout_ready = 2'b00;
    for (int i = 1; i <= 3; i++) push_word(16'h0020 + 16'(i));
    din_valid = 1'b0;
    check("pre_rst_valid", 32'(dout_valid), 32'h3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(dout_valid), 32'd0);
    check("async_rst_ready", 32'(din_ready), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(din_ready), 32'd1);
    check("rst_release_valid", 32'(dout_valid), 32'd0);
    drain();

    // Random consumer backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) push_word(16'(i * 37 + 5));
    rand_mode = 1'b0;
    drain();

`ifdef BC_FIFO_BYPASS_EN
    // Zero-latency bypass on empty channels
    dout_ready = 2'b11;
    din_valid  = 1'b1;
    din_data   = 16'h00AB;
    #1;
    check("bypass_valid", 32'(dout_valid), 32'h3);
    check("bypass_data", dout_data, 32'h00AB_00AB);
    push_word(16'h00AB);
    din_valid = 1'b0;
    #1;
    check("bypass_empty_after", 32'(dout_valid), 32'd0);
    drain();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bc_fifo.md
Name: bc_fifo

Overview:
Parametrised broadcast with per-output elastic buffering, the successor to the lock-step broadcast.
- One input stream is copied to SIZE consumers; each consumer has its own DEPTH-entry FIFO, so a slow consumer does not stall the others until its FIFO fills.
- Sits between a single producer and several independent consumers in the valid/ready stream fabric.

Parameters:
SIZE, 2, number of output channels (>=1)
WIDTH, 16, data width in bits (>=1)
DEPTH, 4, entries per channel FIFO; power of two, >=2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
din_ready  output  1  producer may transfer this cycle
din_valid  input  1  producer data valid
din_data  input  WIDTH  producer data
dout_ready  input  SIZE  bit i: consumer i accepts
dout_valid  output  SIZE  bit i: channel i has data
dout_data  output  SIZE*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]

Behaviour:
- Per channel i: circular buffer of DEPTH words, write/read pointers of log2(DEPTH)+1 bits (MSB = wrap bit).
  - empty when pointers are fully equal.
  - full when the index bits are equal and the wrap bits differ.
- Reset (async, rst=1): all pointers 0; dout_valid=0; din_ready=0 while rst is high. The first cycle after deassertion: din_ready=1. Storage array is not reset. Reset mid-transfer discards all buffered words in every channel.
- din_ready = AND over i of !full[i]. It depends only on registered state, never on dout_ready or din_valid, so there is no combinational ready path.
- Push: din_valid & din_ready. The same word is written to every channel's FIFO in the same cycle and every write pointer increments.
  - A partial push is never allowed: either all channels take the word or none do.
- dout_valid[i] = !empty[i], registered-state only. dout_data[i] = word at the channel-i read pointer.
- Pop i: dout_valid[i] & dout_ready[i]. The channel-i read pointer increments. Channels pop independently.
- Latency: a pushed word appears on dout_valid/dout_data one cycle after the push edge (without the optional feature).
- Simultaneous push and pop on a channel: occupancy unchanged; pointers wrap naturally via the extra bit.
- Full channel with a pop in the same cycle: din_ready is still 0 that cycle (no pass-through on full); room is visible the next cycle.
- Throughput: 1 word/cycle sustained when all consumers are always ready.
- Ordering: each channel delivers words in push order; no loss, no duplication.
- dout_ready asserted while dout_valid=0 has no effect.
- din_valid=0 leaves all write pointers unchanged. din_data is don't-care when no push occurs.

Optional Feature:
BC_FIFO_BYPASS_EN
- Defined: zero-latency bypass for empty channels. When channel i is empty:
  - dout_valid[i] = din_valid & din_ready, and dout_data[i] = din_data.
  - If dout_ready[i]=1 in that cycle, the word is consumed directly and not written into channel i's FIFO (channel i's write pointer holds); other channels still store it normally.
  - If dout_ready[i]=0, the word is written as usual.
  - The bypass path is combinational din_valid -> dout_valid; din_ready stays registered-only.
- Undefined: no bypass; every word passes through storage with the 1-cycle latency above.

Test Plan:
- SIZE=2, DEPTH=4, dout_ready=2'b11, push 0x0001..0x0008 back-to-back -> each channel outputs 0x0001..0x0008 in order; first dout_valid 1 cycle after the first push; din_ready stays 1; throughput 1/cycle.
- dout_ready=2'b01, push 6 words -> din_ready drops after the 4th push (channel 1 full); channel 0 receives 4 words; raise dout_ready[1] -> channel 1 outputs 0x0001..0x0004; din_ready returns 1 the cycle after the first pop; remaining words then reach both channels.
- Channel 1 full, pop and din_valid=1 in the same cycle -> no push that cycle; push accepted the next cycle; channel 1 never over-written.
- Push 3 words, assert rst for 1 cycle asynchronously mid-cycle -> dout_valid=2'b00 and din_ready=0 immediately; after release, din_ready=1 and no stale word appears.
- Random dout_ready per channel (50%), 1000 random words, SIZE=3, DEPTH=8 -> each channel's output sequence equals the input sequence; no overflow or underflow.
- BC_FIFO_BYPASS_EN defined, empty FIFOs, dout_ready=2'b11, push 0x00AB -> dout_valid=2'b11 and dout_data=0x00AB in the same cycle; both FIFOs remain empty the next cycle.
